// File: rtl/vliw_pkg.sv
// Shared VLIW fetch definitions: bundle geometry, opcode field, NOP encoding
// and the fetch FSM state type.
package vliw_pkg;

    localparam int N_SLOTS  = 10;
    localparam int SLOT_W   = 32;
    localparam int BUNDLE_W = N_SLOTS * SLOT_W;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam logic [OPC_HI-OPC_LO:0] NOP_OPC = '0;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        REDIRECT
    } fetch_state_t;

    // A NOP is the all-zero slot: zero opcode and zero operand bits.
    function automatic logic slot_is_nop(input logic [SLOT_W-1:0] slot);
        return (slot[OPC_HI:OPC_LO] == NOP_OPC) && (slot[OPC_LO-1:0] == '0);
    endfunction

endpackage

// File: rtl/vliw_fetch_fifo.sv
// Prefetch FIFO of {pc, bundle} entries with flush; head is read
// combinationally so decode sees the bundle in the same cycle it becomes valid.
module vliw_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 352
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    // Flush wins over both push and pop; a push into a full FIFO is only
    // accepted when the head leaves in the same cycle.
    assign do_pop  = pop && (count_reg != '0) && !flush;
    assign do_push = push && !flush && ((count_reg != FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

endmodule

// File: rtl/vliw_fetch_unit.sv
// VLIW bundle fetch stage: PC, one-cycle imem requests, prefetch FIFO, redirect flush.
// Optional macro VLIW_FETCH_SLOT_MASK_EN builds per-slot non-NOP flags.
module vliw_fetch_unit
    import vliw_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [BUNDLE_W-1:0] imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BUNDLE_W-1:0] out_bundle,
    output logic [PC_W-1:0]     out_pc,
    output logic [N_SLOTS-1:0]  out_slot_mask
);
    localparam int AW      = $clog2(DEPTH);
    localparam int ENTRY_W = PC_W + BUNDLE_W;
    localparam logic [AW+1:0] DEPTH_V = (AW+2)'(DEPTH);

    fetch_state_t     state_reg;
    fetch_state_t     state_next;
    logic [PC_W-1:0]  pc_reg;
    logic [PC_W-1:0]  pc_next;
    logic             epoch_reg;
    logic             inflight_reg;
    logic             inflight_epoch_reg;
    logic [PC_W-1:0]  inflight_pc_reg;

    logic [AW:0]        count;
    logic [ENTRY_W-1:0] head;
    logic               room;
    logic               issue;
    logic               push;
    logic               pop;

    // Credit check: buffered bundles plus the one in flight must fit the FIFO.
    assign room = ({1'b0, count} + {{(AW+1){1'b0}}, inflight_reg}) < DEPTH_V;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= BOOT;
            pc_reg             <= '0;
            epoch_reg          <= 1'b0;
            inflight_reg       <= 1'b0;
            inflight_epoch_reg <= 1'b0;
            inflight_pc_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            inflight_reg <= issue;
            if (issue) begin
                inflight_pc_reg    <= pc_reg;
                inflight_epoch_reg <= epoch_reg;
            end
            if (redirect_valid) begin
                epoch_reg <= ~epoch_reg;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        pc_next    = pc_reg;
        case (state_reg)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    state_next = REDIRECT;
                end else begin
                    issue = room;
                end
            end
            REDIRECT: begin
                if (!redirect_valid) begin
                    state_next = RUN;
                    issue      = room;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
        if (issue) begin
            pc_next = pc_reg + 1'b1;
        end
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = pc_reg;

    // Responses from before the latest redirect carry a stale epoch and are dropped.
    assign push = inflight_reg && (inflight_epoch_reg == epoch_reg) && !redirect_valid;
    assign pop  = out_valid && out_ready && !redirect_valid;

    vliw_fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({inflight_pc_reg, imem_rdata}),
        .count (count),
        .head  (head)
    );

    assign out_valid  = (count != '0);
    assign out_pc     = out_valid ? head[ENTRY_W-1 -: PC_W] : '0;
    assign out_bundle = out_valid ? head[BUNDLE_W-1:0] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < N_SLOTS; gi++) begin : g_mask
`ifdef VLIW_FETCH_SLOT_MASK_EN
            logic [SLOT_W-1:0] slot;
            assign slot              = out_bundle[gi*SLOT_W +: SLOT_W];
            assign out_slot_mask[gi] = out_valid && !slot_is_nop(slot);
`else
            assign out_slot_mask[gi] = out_valid;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_vliw_fetch_unit.sv
// Self-checking bench for vliw_fetch_unit: transaction-level reference model
// plus directed latency/stall/redirect/wrap/mask checks and a random phase.
module tb_vliw_fetch_unit;
    import vliw_pkg::*;

    localparam int DEPTH = 4;
    typedef logic [BUNDLE_W-1:0] wide_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                imem_req;
    logic [31:0]         imem_addr;
    logic [BUNDLE_W-1:0] imem_rdata;
    logic                redirect_valid;
    logic [31:0]         redirect_pc;
    logic                out_valid;
    logic                out_ready;
    logic [BUNDLE_W-1:0] out_bundle;
    logic [31:0]         out_pc;
    logic [N_SLOTS-1:0]  out_slot_mask;

    int checks = 0;
    int errors = 0;

    vliw_fetch_unit #(.PC_W(32), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_bundle     (out_bundle),
        .out_pc         (out_pc),
        .out_slot_mask  (out_slot_mask)
    );

    always #5 clk = ~clk;

    // Bundle stored at address a; 0x77 holds a single non-NOP slot in slot 5.
    function automatic wide_t gen_bundle(input logic [31:0] a);
        wide_t       b;
        logic [31:0] x;
        b = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (a == 32'h77) begin
                x = (i == 5) ? 32'h4A0C3000 : 32'h0;
            end else begin
                x = a * 32'h9E3779B1 + 32'(i) * 32'h85EBCA6B;
                if (x[31:29] == 3'b000) x = '0;
            end
            b[i*SLOT_W +: SLOT_W] = x;
        end
        return b;
    endfunction

    function automatic wide_t rand_bundle();
        wide_t b;
        for (int i = 0; i < N_SLOTS; i++) b[i*SLOT_W +: SLOT_W] = $urandom;
        return b;
    endfunction

    function automatic logic [N_SLOTS-1:0] exp_mask(input logic [31:0] a);
        logic [N_SLOTS-1:0] m;
        wide_t b;
        b = gen_bundle(a);
        for (int i = 0; i < N_SLOTS; i++) begin
`ifdef VLIW_FETCH_SLOT_MASK_EN
            m[i] = (b[i*SLOT_W +: SLOT_W] != 32'h0);
`else
            m[i] = 1'b1;
`endif
        end
        return m;
    endfunction

    task automatic chk(input string name, input wide_t act, input wide_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory: data for the requested address one cycle later, junk otherwise.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= gen_bundle(imem_addr);
        else          imem_rdata <= rand_bundle();
    end

    // Reference model: requests issued since the last flush that are not yet
    // consumed, each with its issue cycle; a bundle is visible two cycles after issue.
    int          cyc = 0;
    int          q_cyc[$];
    logic [31:0] q_pc[$];
    logic [31:0] exp_req_pc = '0;
    logic        boot = 1'b1;
    logic        exp_valid;
    logic        exp_req;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q_cyc.delete();
            q_pc.delete();
            exp_req_pc = '0;
            boot       = 1'b1;
        end else begin
            exp_valid = (q_cyc.size() > 0) && (q_cyc[0] <= cyc - 2);
            chk("out_valid", wide_t'(out_valid), wide_t'(exp_valid));
            if (exp_valid && out_valid) begin
                chk("out_pc", wide_t'(out_pc), wide_t'(q_pc[0]));
                chk("out_bundle", out_bundle, gen_bundle(q_pc[0]));
                chk("out_slot_mask", wide_t'(out_slot_mask), wide_t'(exp_mask(q_pc[0])));
            end
            if (!out_valid) chk("idle_mask", wide_t'(out_slot_mask), wide_t'(0));
            if (boot) begin
                chk("boot_out_pc", wide_t'(out_pc), wide_t'(0));
                chk("boot_out_bundle", out_bundle, wide_t'(0));
            end
            exp_req = !redirect_valid && !boot && (q_cyc.size() < DEPTH);
            chk("imem_req", wide_t'(imem_req), wide_t'(exp_req));
            if (imem_req && exp_req) chk("imem_addr", wide_t'(imem_addr), wide_t'(exp_req_pc));
            if (exp_valid && out_ready && !redirect_valid) begin
                void'(q_cyc.pop_front());
                void'(q_pc.pop_front());
            end
            if (exp_req) begin
                q_cyc.push_back(cyc);
                q_pc.push_back(exp_req_pc);
                exp_req_pc = exp_req_pc + 32'd1;
            end
            if (redirect_valid) begin
                q_cyc.delete();
                q_pc.delete();
                exp_req_pc = redirect_pc;
            end
            boot = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles from the current one until out_valid, bounded.
    task automatic wait_valid(input int start, output int k);
        k = start;
        while (k < 12) begin
            @(negedge clk);
            if (out_valid) return;
            tick();
            k++;
        end
    endtask

    task automatic redirect_measure(input logic [31:0] target, input string name);
        int k;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
        wait_valid(1, k);
        chk({name, "_latency"}, wide_t'(k), wide_t'(3));
        chk({name, "_pc"}, wide_t'(out_pc), wide_t'(target));
        tick();
    endtask

    initial begin
        int k;
        int n;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        repeat (3) tick();

        // Reset release: first bundle visible three cycles later, then streaming.
        rst       = 1'b0;
        out_ready = 1'b1;
        wait_valid(0, k);
        chk("reset_latency", wide_t'(k), wide_t'(3));
        chk("reset_first_pc", wide_t'(out_pc), wide_t'(0));
        repeat (20) tick();

        // Decode stalled: only DEPTH requests may be outstanding.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req) n++;
            tick();
        end
        chk("stall_requests", wide_t'(n), wide_t'(4));
        @(negedge clk);
        chk("stall_hold_pc", wide_t'(out_pc), wide_t'(0));
        tick();
        out_ready = 1'b1;
        repeat (20) tick();

        // Redirect with a partially filled FIFO and a request in flight.
        out_ready = 1'b0;
        repeat (2) tick();
        redirect_measure(32'h40, "redirect_40");
        out_ready = 1'b1;
        repeat (6) tick();

        // Back-to-back redirects: only the second target is fetched.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_measure(32'h20, "redirect_20");
        repeat (6) tick();

        // Reset mid-stream with a request in flight.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_valid(0, k);
        chk("midreset_latency", wide_t'(k), wide_t'(3));
        chk("midreset_pc", wide_t'(out_pc), wide_t'(0));
        repeat (4) tick();

        // PC wrap-around.
        redirect_measure(32'hFFFFFFFF, "wrap");
        @(negedge clk);
        chk("wrap_next_pc", wide_t'(out_pc), wide_t'(0));
        tick();

        // Slot mask on a bundle holding only slot 5.
        out_ready = 1'b0;
        redirect_measure(32'h77, "mask");
        @(negedge clk);
`ifdef VLIW_FETCH_SLOT_MASK_EN
        chk("mask_slot5", wide_t'(out_slot_mask), wide_t'(10'b0000100000));
`else
        chk("mask_slot5", wide_t'(out_slot_mask), wide_t'(10'b1111111111));
`endif
        tick();
        out_ready = 1'b1;
        repeat (4) tick();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 99) < 4);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFF - 32'($urandom_range(0, 3)))
                                                         : 32'($urandom_range(0, 255));
            rst            = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst            = 1'b0;
        redirect_valid = 1'b0;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
